// File: rtl/fabm_pkg.sv
// fabm_pkg: constants and types shared by the FABM partial-product /
// propagate-generate stage.
//   FABM_W         operand width
//   FABM_PW        product width
//   FABM_SPLIT     lowest bit handled by the downstream carry chain
//   FABM_ROW_SPLIT first partial-product row that belongs to Y
//   fabm_row_t     one 32-bit product row
//   fabm_pg_t      propagate/generate vector for bits [31:SPLIT]
package fabm_pkg;
  localparam int FABM_W         = 16;
  localparam int FABM_PW        = 32;
  localparam int FABM_SPLIT     = 10;
  localparam int FABM_ROW_SPLIT = 8;
  localparam int FABM_PGW       = FABM_PW - FABM_SPLIT;

  typedef logic [FABM_PW-1:0]  fabm_row_t;
  typedef logic [FABM_PGW-1:0] fabm_pg_t;
endpackage

// File: rtl/fabm_pg_stage_if.sv
// fabm_pg_stage_if: operand input and pg/LOA result output of the stage.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds data stable while valid=1 and ready=0;
// ready never depends on valid in the same cycle.
//   slave  - the stage (consumes operands, produces results)
//   master - the environment driving operands and accepting results
interface fabm_pg_stage_if;
  import fabm_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [FABM_W-1:0]     a_i;
  logic [FABM_W-1:0]     b_i;
  logic                  out_valid;
  logic                  out_ready;
  fabm_pg_t              prop_o;
  fabm_pg_t              gen_o;
  logic                  cin_o;
  logic [FABM_SPLIT-1:0] lo_o;

  modport slave (
    input  in_valid, a_i, b_i, out_ready,
    output in_ready, out_valid, prop_o, gen_o, cin_o, lo_o
  );

  modport master (
    output in_valid, a_i, b_i, out_ready,
    input  in_ready, out_valid, prop_o, gen_o, cin_o, lo_o
  );
endinterface

// File: rtl/fabm_pp_row_sum.sv
// fabm_pp_row_sum: builds eight partial-product rows ROW_LO..ROW_LO+7 of a
// signed 16x16 product and sums them with a balanced adder tree (mod 2^32).
//   i_a   multiplicand, two's complement
//   i_b   multiplier, two's complement
//   o_sum sum of the selected rows
module fabm_pp_row_sum
  import fabm_pkg::*;
#(
  parameter int ROW_LO = 0
) (
  input  logic [FABM_W-1:0] i_a,
  input  logic [FABM_W-1:0] i_b,
  output fabm_row_t         o_sum
);

  fabm_row_t w_a_ext;
  fabm_row_t w_pp [8];
  fabm_row_t w_l1 [4];
  fabm_row_t w_l2 [2];

  assign w_a_ext = {{(FABM_PW-FABM_W){i_a[FABM_W-1]}}, i_a};

  for (genvar g = 0; g < 8; g++) begin : g_row
    localparam int ROW = ROW_LO + g;
    if (ROW == FABM_W - 1) begin : g_neg
      // Multiplier MSB carries weight -2^15 in two's complement.
      assign w_pp[g] = i_b[ROW] ? (fabm_row_t'(0) - (w_a_ext << ROW)) : '0;
    end else begin : g_pos
      assign w_pp[g] = i_b[ROW] ? (w_a_ext << ROW) : '0;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_l1
    assign w_l1[g] = w_pp[2*g] + w_pp[2*g+1];
  end

  for (genvar g = 0; g < 2; g++) begin : g_l2
    assign w_l2[g] = w_l1[2*g] + w_l1[2*g+1];
  end

  assign o_sum = w_l2[0] + w_l2[1];

endmodule

// File: rtl/fabm_pg_stage.sv
// fabm_pg_stage: two-stage valid/ready pipeline feeding the FABM carry chain.
// S1 registers the row sums X (rows 0..7) and Y (rows 8..15); S2 registers
// propagate/generate for bits [31:10], the OR-approximated low bits [9:0]
// and the approximate carry-in X[9]&Y[9].
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   slave side of fabm_pg_stage_if (operands in, pg/LOA results out)
module fabm_pg_stage
  import fabm_pkg::*;
#(
  parameter int SPLIT     = FABM_SPLIT,
  parameter int ROW_SPLIT = FABM_ROW_SPLIT,
  parameter int W         = FABM_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fabm_pg_stage_if.slave        bus
);

  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  fabm_row_t    w_x;
  fabm_row_t    w_y;
  logic         w_s1_load;
  logic         w_s2_load;
  logic         w_in_ready;

  logic             r_v1;
  logic             r_v2;
  fabm_row_t        r_x;
  fabm_row_t        r_y;
  fabm_pg_t         r_prop;
  fabm_pg_t         r_gen;
  logic             r_cin;
  logic [SPLIT-1:0] r_lo;

  assign w_a = bus.a_i;
  assign w_b = bus.b_i;

  fabm_pp_row_sum #(.ROW_LO(0)) u_sum_x (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_sum (w_x)
  );

  fabm_pp_row_sum #(.ROW_LO(ROW_SPLIT)) u_sum_y (
    .i_a   (w_a),
    .i_b   (w_b),
    .o_sum (w_y)
  );

  // S2 frees up when it is empty or its result leaves this cycle; S1 can
  // accept whenever it is empty or will hand its content to S2.
  assign w_s2_load  = r_v1 & (~r_v2 | bus.out_ready);
  assign w_in_ready = ~r_v1 | ~r_v2 | bus.out_ready;
  assign w_s1_load  = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_prop <= '0;
      r_gen  <= '0;
      r_cin  <= 1'b0;
      r_lo   <= '0;
    end else begin
      if (w_s1_load) begin
        r_v1 <= 1'b1;
        r_x  <= w_x;
        r_y  <= w_y;
      end else if (w_s2_load) begin
        r_v1 <= 1'b0;
      end

      if (w_s2_load) begin
        r_v2   <= 1'b1;
        r_prop <= r_x[FABM_PW-1:SPLIT] ^ r_y[FABM_PW-1:SPLIT];
        r_gen  <= r_x[FABM_PW-1:SPLIT] & r_y[FABM_PW-1:SPLIT];
        r_cin  <= r_x[SPLIT-1] & r_y[SPLIT-1];
        r_lo   <= r_x[SPLIT-1:0] | r_y[SPLIT-1:0];
      end else if (bus.out_ready) begin
        r_v2 <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_v2;
  assign bus.prop_o    = r_prop;
  assign bus.gen_o     = r_gen;
  assign bus.cin_o     = r_cin;
  assign bus.lo_o      = r_lo;

endmodule

// File: doc/fabm_pg_stage.md
Name: fabm_pg_stage

Overview:
- Upstream feeder for the FABM 16x16 signed multiplier's final carry-chain adder, which covers bits [31:10] with a carry-in.
- Takes two signed 16-bit operands and reduces the partial products to two 32-bit rows X and Y.
- Emits per-bit propagate/generate for bits [31:10], a lower-part OR approximation for bits [9:0], and the approximate carry-in.
- Two-stage valid/ready pipeline with full backpressure.

Parameters:
- SPLIT, 10: lowest bit handled by the downstream carry chain. Fixed at 10; the port widths depend on it.
- ROW_SPLIT, 8: partial-product rows 0..ROW_SPLIT-1 form X, the remaining rows form Y.
- W, 16: operand width. Only 16 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept an operand pair
- a_i  in  16  multiplicand, two's complement
- b_i  in  16  multiplier, two's complement
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- prop_o  out  22  (X^Y)[31:10], drives the adder's propagate input
- gen_o  out  22  (X&Y)[31:10], drives the adder's generate input
- cin_o  out  1  X[9] & Y[9], approximate carry into bit 10
- lo_o  out  10  (X|Y)[9:0], approximate low product bits

Behaviour:
- Reset is asynchronous and active-low (rst_n), on the single clock clk. While rst_n=0: both stage valids=0, out_valid=0, in_ready=1, prop_o/gen_o/lo_o=0, cin_o=0. Data registers are also cleared.
- Partial products, 32-bit, with sign-extended A: pp_i = B[i] ? (A<<i) : 0 for i=0..14; pp_15 = B[15] ? -(A<<15) : 0 (two's complement weight).
  - X = sum of pp_0..pp_7 mod 2^32.
  - Y = sum of pp_8..pp_15 mod 2^32.
  - Invariant: X+Y == A*B mod 2^32 exactly. Y[7:0] is always 0.
- Stage 1 (S1): on a transfer in (in_valid & in_ready), register X and Y and set v1=1. Implement the row sums as an adder tree, not a multiplier operator.
- Stage 2 (S2): register prop, gen, cin and lo from the S1 contents and set v2=1. The outputs are the S2 registers directly. out_valid=v2.
- Latency: a transfer in at cycle t gives out_valid=1 at t+2 with no backpressure. Throughput is 1 per cycle.
- Advance rules:
  - S2 loads when v1 & (!v2 | out_ready).
  - S1 loads when in_valid & in_ready.
  - in_ready = !v1 | (!v2 | out_ready). This is combinational from registers and out_ready only, never from in_valid.
- Simultaneous events:
  - Output drained and S1 moving into S2 in the same cycle: no bubble.
  - New input and S1 moving in the same cycle: S1 takes the new data, and v1 stays 1.
  - Output drained with no new S1 data: v2 clears.
- Full condition: v1=v2=1 and out_ready=0 gives in_ready=0. All registers hold, and outputs stay stable while out_valid=1 and out_ready=0.
- Ordering is strictly FIFO. Nothing is dropped or duplicated.
- Reset mid-operation discards every in-flight item. The first cycle after deassertion behaves as after power-up.
- Approximation is confined to lo_o and cin_o (lower-part OR adder). prop_o and gen_o are exact functions of X and Y.

Decomposition:
- Shared package fabm_pkg:
  - constants FABM_W=16, FABM_PW=32, FABM_SPLIT=10, FABM_ROW_SPLIT=8
  - typedef for the 32-bit product row and the 22-bit pg vector
- One natural sub-module: fabm_pp_row_sum. It builds the pp_i for a given row range, including the negative weight of row 15, and sums them. Instantiate it twice, for X and Y.
- Handshake and pg/LOA logic live in the top module.

Test Plan:
- A=3, B=5 -> X=15, Y=0 -> after 2 cycles: prop_o=0, gen_o=0, cin_o=0, lo_o=10'h00F.
- A=16'hFFFF, B=16'h0100 -> Y=32'hFFFFFF00, X=0 -> prop_o=22'h3FFFFF, gen_o=0, cin_o=0, lo_o=10'h300. Feeding this into the adder model gives 32'hFFFFFF00 (=-256).
- A=16'h0202, B=16'h0101 -> X=32'h202, Y=32'h20200 -> prop_o=22'h80, gen_o=0, cin_o=1, lo_o=10'h202.
- Backpressure: out_ready=0, push 3 back-to-back pairs -> 2 accepted, in_ready=0 from the cycle after the 2nd accept, outputs stable. Then out_ready=1 -> all 3 results delivered in order with no gap.
- Streaming: 1000 random pairs with random out_ready. Check:
  - prop^... bench rebuilds X+Y from prop/gen, and (prop+2*gen)<<10 matches (A*B - X_lo - Y_lo) mod 2^32
  - lo_o and cin_o match the model
  - count out == count in
- Reset: assert rst_n=0 with v1=v2=1 -> out_valid=0 and in_ready=1 immediately. After release, the first output is from the first post-reset input.
